ma_stage_wbuf: RTL and testbench

// Memory-access pipeline stage with a parametrised store buffer, between EX and WB.

---
 rtl/ma_stage_wbuf.sv | 211 +++++++++++++++++++++
 tb/tb_ma_stage_wbuf.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_stage_wbuf.sv
// Memory-access stage between EX and WB with a store buffer drained to memory in the background.
// Define MA_WBUF_MERGE_EN to merge same-word stores into the youngest buffered entry.
module ma_stage_wbuf #(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst_p,
    input  logic                      flush,
    input  logic                      EX_ready,
    output logic                      MA_enable,
    input  logic                      WB_enable,
    output logic                      MA_ready,
    input  logic                      in_mem_read,
    input  logic                      in_mem_write,
    input  logic [6:0]                in_align_load,
    input  logic [4:0]                in_align_store,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [31:0]               in_wdata,
    output logic                      mem_req,
    output logic                      mem_wr,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [2:0]                mem_size,
    output logic [3:0]                mem_wstrb,
    output logic [31:0]               mem_wdata,
    input  logic                      mem_gnt,
    output logic                      sb_empty,
    output logic [$clog2(SB_DEPTH):0] sb_count
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(SB_DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

    function automatic logic [3:0] st_strb(input logic [4:0] st, input logic [1:0] a);
        if (st[4])      return 4'b1111;
        else if (st[3]) return 4'b0001 << a;
        else if (st[2]) return a[1] ? 4'b1100 : 4'b0011;
        else if (st[1]) return {a == 2'd3, a[1], a != 2'd0, 1'b1};
        else if (st[0]) return {1'b1, a != 2'd3, !a[1], a == 2'd0};
        else            return 4'b0000;
    endfunction

    function automatic logic [31:0] st_data(input logic [4:0] st, input logic [1:0] a,
                                            input logic [31:0] rt);
        if (st[3])      return {24'h0, rt[7:0]} << {a, 3'b000};
        else if (st[2]) return a[1] ? {rt[15:0], 16'h0} : {16'h0, rt[15:0]};
        else if (st[1]) return rt >> {~a, 3'b000};
        else if (st[0]) return rt << {a, 3'b000};
        else            return rt;
    endfunction

    function automatic logic [2:0] st_size(input logic [4:0] st);
        if (st[3])      return 3'd1;
        else if (st[2]) return 3'd2;
        else            return 3'd4;
    endfunction

    function automatic logic [2:0] ld_size(input logic [6:0] ld);
        if (ld[5] || ld[4])      return 3'd1;
        else if (ld[3] || ld[2]) return 3'd2;
        else                     return 3'd4;
    endfunction

    logic              valid_q, valid_d, rd_q, wr_q;
    logic [6:0]        ld_q;
    logic [4:0]        st_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              lock_q, lock_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [SB_DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [WA_W-1:0]   ent_wa_q   [SB_DEPTH];
    logic [3:0]        ent_strb_q [SB_DEPTH];
    logic [31:0]       ent_data_q [SB_DEPTH];
    logic [2:0]        ent_size_q [SB_DEPTH];

    logic [WA_W-1:0] op_wa;
    logic [3:0]      new_strb;
    logic [31:0]     new_data;
    logic [2:0]      new_size;
    logic conflict, load_want, sb_nempty, drain_sel, pop, merge_hit, full;
    logic st_go, ld_go, leave, push;

    assign op_wa    = addr_q[ADDR_W-1:2];
    assign new_strb = st_strb(st_q, addr_q[1:0]);
    assign new_data = st_data(st_q, addr_q[1:0], wdata_q);
    assign new_size = st_size(st_q);

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (ent_vld_q[i] && (ent_wa_q[i] == op_wa)) conflict = 1'b1;
        end
    end

    // A drain that was offered and not yet granted keeps the port so the request stays stable.
    assign load_want = valid_q && rd_q && !conflict;
    assign sb_nempty = (count_q != '0);
    assign drain_sel = sb_nempty && (lock_q || !load_want);
    assign pop       = drain_sel && mem_gnt;
    assign full      = (count_q == CNT_FULL);

`ifdef MA_WBUF_MERGE_EN
    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // A narrow size survives only when one access already covers the other.
    function automatic logic [2:0] merge_size(input logic [3:0] old_s, input logic [3:0] new_s,
                                              input logic [2:0] old_z, input logic [2:0] new_z);
        if ((old_s | new_s) == old_s)      return old_z;
        else if ((old_s | new_s) == new_s) return new_z;
        else                               return 3'd4;
    endfunction

    logic [PTR_W-1:0] tail_last;
    assign tail_last = tail_q - PTR_W'(1);
    assign merge_hit = valid_q && wr_q && ent_vld_q[tail_last] && (ent_wa_q[tail_last] == op_wa)
                       && !(pop && (count_q == CNT_ONE));
`else
    assign merge_hit = 1'b0;
`endif

    assign st_go = valid_q && wr_q && (merge_hit || !full || pop);
    assign ld_go = load_want && !drain_sel && mem_gnt;

    always_comb begin
        MA_ready = 1'b0;
        if (valid_q) begin
            if (rd_q)      MA_ready = ld_go;
            else if (wr_q) MA_ready = st_go;
            else           MA_ready = 1'b1;
        end
    end

    assign leave     = MA_ready && WB_enable;
    assign push      = leave && wr_q && !merge_hit;
    assign MA_enable = !valid_q || leave;

    assign mem_req   = load_want || sb_nempty;
    assign mem_wr    = drain_sel;
    assign mem_addr  = drain_sel ? {ent_wa_q[head_q], 2'b00} : {op_wa, 2'b00};
    assign mem_size  = drain_sel ? ent_size_q[head_q] : ld_size(ld_q);
    assign mem_wstrb = drain_sel ? ent_strb_q[head_q] : 4'b0000;
    assign mem_wdata = drain_sel ? ent_data_q[head_q] : 32'h0;
    assign sb_empty  = !sb_nempty;
    assign sb_count  = count_q;

    always_comb begin
        valid_d = valid_q;
        if (leave) valid_d = 1'b0;
        if (MA_enable && EX_ready) valid_d = 1'b1;
        if (flush) valid_d = 1'b0;
        lock_d    = drain_sel && !mem_gnt;
        head_d    = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d    = push ? tail_q + PTR_W'(1) : tail_q;
        count_d   = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
        ent_vld_d = ent_vld_q;
        if (pop)  ent_vld_d[head_q] = 1'b0;
        if (push) ent_vld_d[tail_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            valid_q   <= 1'b0;
            lock_q    <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ent_vld_q <= '0;
        end else begin
            valid_q   <= valid_d;
            lock_q    <= lock_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ent_vld_q <= ent_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (MA_enable && EX_ready) begin
            rd_q    <= in_mem_read;
            wr_q    <= in_mem_write;
            ld_q    <= in_align_load;
            st_q    <= in_align_store;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
        end
        if (push) begin
            ent_wa_q[tail_q]   <= op_wa;
            ent_strb_q[tail_q] <= new_strb;
            ent_data_q[tail_q] <= new_data;
            ent_size_q[tail_q] <= new_size;
        end
`ifdef MA_WBUF_MERGE_EN
        if (leave && merge_hit) begin
            ent_strb_q[tail_last] <= ent_strb_q[tail_last] | new_strb;
            ent_data_q[tail_last] <= (ent_data_q[tail_last] & ~byte_mask(new_strb))
                                     | (new_data & byte_mask(new_strb));
            ent_size_q[tail_last] <= merge_size(ent_strb_q[tail_last], new_strb,
                                                ent_size_q[tail_last], new_size);
        end
`endif
    end

endmodule

// File: tb/tb_ma_stage_wbuf.sv
// Bench for ma_stage_wbuf: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_ma_stage_wbuf;
    localparam int D  = 4;
    localparam int AW = 32;
    localparam logic [4:0] SW = 5'b10000, SB = 5'b01000, SWL = 5'b00010, SWR = 5'b00001;
    localparam logic [6:0] LW = 7'b1000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_p, flush, EX_ready, MA_enable, WB_enable, MA_ready;
    logic in_mem_read, in_mem_write;
    logic [6:0] in_align_load;
    logic [4:0] in_align_store;
    logic [AW-1:0] in_addr, mem_addr;
    logic [31:0] in_wdata, mem_wdata;
    logic mem_req, mem_wr, mem_gnt, sb_empty;
    logic [2:0] mem_size;
    logic [3:0] mem_wstrb;
    logic [$clog2(D):0] sb_count;

    ma_stage_wbuf #(.SB_DEPTH(D), .ADDR_W(AW)) dut (
        .clk(clk), .rst_p(rst_p), .flush(flush), .EX_ready(EX_ready), .MA_enable(MA_enable),
        .WB_enable(WB_enable), .MA_ready(MA_ready), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_align_load(in_align_load), .in_align_store(in_align_store),
        .in_addr(in_addr), .in_wdata(in_wdata), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .sb_empty(sb_empty), .sb_count(sb_count)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [29:0] wa;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [2:0]  size;
    } ent_t;

    ent_t q[$];
    bit m_valid, m_rd, m_wr, m_lock;
    logic [6:0] m_ld;
    logic [4:0] m_st;
    logic [31:0] m_addr, m_wd;

    function automatic ent_t make_ent(input logic [4:0] st, input logic [31:0] addr,
                                      input logic [31:0] rt);
        ent_t e;
        int a;
        a = int'(addr[1:0]);
        e.wa = addr[31:2];
        if (st[4]) begin
            e.strb = 4'hF; e.data = rt; e.size = 3'd4;
        end else if (st[3]) begin
            e.strb = 4'(1 << a); e.data = (rt & 32'hFF) << (8 * a); e.size = 3'd1;
        end else if (st[2]) begin
            e.strb = (a >= 2) ? 4'hC : 4'h3;
            e.data = (rt & 32'hFFFF) << ((a >= 2) ? 16 : 0); e.size = 3'd2;
        end else if (st[1]) begin
            e.strb = 4'((1 << (a + 1)) - 1); e.data = rt >> (8 * (3 - a)); e.size = 3'd4;
        end else begin
            e.strb = 4'(32'hF << a); e.data = rt << (8 * a); e.size = 3'd4;
        end
        return e;
    endfunction

    function automatic logic [2:0] load_bytes(input logic [6:0] ld);
        if (ld[5] || ld[4]) return 3'd1;
        if (ld[3] || ld[2]) return 3'd2;
        return 3'd4;
    endfunction

    function automatic bit word_buffered(input logic [31:0] addr);
        foreach (q[i]) if (q[i].wa == addr[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    // Predict this cycle's outputs from the current inputs, compare, then advance the model.
    task automatic model_cycle();
        bit load_want, drain, pop, merge, st_go, ld_go, mready, leave, menable;
        ent_t e, t;
        logic [31:0] mask;
        load_want = m_valid && m_rd && !word_buffered(m_addr);
        drain = (q.size() > 0) && (m_lock || !load_want);
        pop = drain && mem_gnt;
        merge = 1'b0;
`ifdef MA_WBUF_MERGE_EN
        if (m_valid && m_wr && q.size() > 0 && q[q.size()-1].wa == m_addr[31:2]
            && !(pop && q.size() == 1)) merge = 1'b1;
`endif
        st_go = m_valid && m_wr && (merge || q.size() < D || pop);
        ld_go = load_want && !drain && mem_gnt;
        mready = m_valid && (m_rd ? ld_go : (m_wr ? st_go : 1'b1));
        leave = mready && WB_enable;
        menable = !m_valid || leave;

        chk("mem_req", mem_req, load_want || q.size() > 0);
        if (drain) begin
            chk("mem_wr", mem_wr, 1'b1);
            chk("drain_addr", mem_addr, {q[0].wa, 2'b00});
            chk("drain_strb", mem_wstrb, q[0].strb);
            chk("drain_data", mem_wdata, q[0].data);
            chk("drain_size", mem_size, q[0].size);
        end else if (load_want) begin
            chk("mem_wr", mem_wr, 1'b0);
            chk("load_addr", mem_addr, {m_addr[31:2], 2'b00});
            chk("load_size", mem_size, load_bytes(m_ld));
        end
        chk("MA_ready", MA_ready, mready);
        chk("MA_enable", MA_enable, menable);
        chk("sb_count", sb_count, q.size());
        chk("sb_empty", sb_empty, q.size() == 0);

        if (rst_p) begin
            q.delete();
            m_valid = 1'b0;
            m_lock = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (leave && m_wr) begin
                e = make_ent(m_st, m_addr, m_wd);
                if (merge) begin
                    t = q[q.size()-1];
                    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{e.strb[b]}};
                    t.data = (t.data & ~mask) | (e.data & mask);
                    if ((t.strb | e.strb) == t.strb) t.size = t.size;
                    else if ((t.strb | e.strb) == e.strb) t.size = e.size;
                    else t.size = 3'd4;
                    t.strb = t.strb | e.strb;
                    q[q.size()-1] = t;
                end else begin
                    q.push_back(e);
                end
            end
            m_lock = drain && !mem_gnt;
            if (flush) m_valid = 1'b0;
            else if (menable && EX_ready) begin
                m_valid = 1'b1; m_rd = in_mem_read; m_wr = in_mem_write;
                m_ld = in_align_load; m_st = in_align_store; m_addr = in_addr; m_wd = in_wdata;
            end else if (leave) m_valid = 1'b0;
        end
    endtask

    logic n_rd, n_wr;
    logic [6:0] n_ld;
    logic [4:0] n_st;
    logic [31:0] n_addr, n_wd;

    task automatic op_st(input logic [4:0] st, input logic [31:0] a, input logic [31:0] d);
        n_rd = 1'b0; n_wr = 1'b1; n_ld = '0; n_st = st; n_addr = a; n_wd = d;
    endtask
    task automatic op_ld(input logic [6:0] ld, input logic [31:0] a);
        n_rd = 1'b1; n_wr = 1'b0; n_ld = ld; n_st = '0; n_addr = a; n_wd = '0;
    endtask
    task automatic op_nop();
        n_rd = 1'b0; n_wr = 1'b0; n_ld = '0; n_st = '0; n_addr = '0; n_wd = '0;
    endtask

    task automatic cyc(input bit ex, input bit g, input bit f = 1'b0, input bit r = 1'b0);
        @(posedge clk);
        #1;
        EX_ready = ex; mem_gnt = g; flush = f; rst_p = r;
        in_mem_read = n_rd; in_mem_write = n_wr; in_align_load = n_ld; in_align_store = n_st;
        in_addr = n_addr; in_wdata = n_wd;
        @(negedge clk);
        model_cycle();
    endtask

    initial begin
        rst_p = 1'b1; flush = 1'b0; EX_ready = 1'b0; WB_enable = 1'b1; mem_gnt = 1'b0;
        in_mem_read = 1'b0; in_mem_write = 1'b0; in_align_load = '0; in_align_store = '0;
        in_addr = '0; in_wdata = '0;
        m_valid = 1'b0; m_lock = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
        m_ld = '0; m_st = '0; m_addr = '0; m_wd = '0;
        op_nop();
        repeat (3) @(posedge clk);
        cyc(0, 0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_MA_ready", MA_ready, 1'b0);
        chk("rst_sb_empty", sb_empty, 1'b1);
        chk("rst_sb_count", sb_count, 0);

        // sb into the top lane, drained after a single grant
        op_st(SB, 32'h1003, 32'h000000AB); cyc(1, 0);
        op_nop(); cyc(0, 0); cyc(0, 0);
        chk("sb_count1", sb_count, 1);
        chk("sb_wr", mem_wr, 1'b1);
        chk("sb_strb", mem_wstrb, 4'b1000);
        chk("sb_data", mem_wdata, 32'hAB000000);
        chk("sb_size", mem_size, 3'd1);
        cyc(0, 1); cyc(0, 0);
        chk("sb_drained", sb_count, 0);

        // fill the buffer, fifth store waits, then leaves on the pop edge
        for (int i = 0; i < 5; i++) begin
            op_st(SW, 32'h5000 + 32'(4 * i), 32'(i)); cyc(1, 0);
        end
        op_nop(); cyc(0, 0);
        chk("full_stall", MA_ready, 1'b0);
        chk("full_count", sb_count, 4);
        cyc(0, 1);
        chk("full_leave", MA_ready, 1'b1);
        cyc(0, 0);
        chk("full_count_kept", sb_count, 4);
        repeat (4) cyc(0, 1);
        cyc(0, 0);
        chk("full_drained", sb_empty, 1'b1);

        // load to another word bypasses; same-word load waits for the pop
        op_st(SW, 32'h2000, 32'h12345678); cyc(1, 0);
        op_ld(LW, 32'h2004); cyc(1, 0);
        op_nop(); cyc(0, 0);
        chk("byp_wr", mem_wr, 1'b0);
        chk("byp_addr", mem_addr, 32'h2004);
        cyc(0, 1);
        chk("byp_leave", MA_ready, 1'b1);
        op_ld(LW, 32'h2002); cyc(1, 0);
        op_nop(); cyc(0, 0);
        chk("raw_stall", MA_ready, 1'b0);
        chk("raw_drain", mem_wr, 1'b1);
        cyc(0, 1);
        chk("raw_stall2", MA_ready, 1'b0);
        cyc(0, 1);
        chk("raw_load_wr", mem_wr, 1'b0);
        chk("raw_load_addr", mem_addr, 32'h2000);
        chk("raw_leave", MA_ready, 1'b1);
        cyc(0, 0);

        // swl / swr lane alignment
        op_st(SWL, 32'h3001, 32'h11223344); cyc(1, 0);
        op_nop(); cyc(0, 0); cyc(0, 0);
        chk("swl_strb", mem_wstrb, 4'b0011);
        chk("swl_data", mem_wdata, 32'h00001122);
        chk("swl_size", mem_size, 3'd4);
        cyc(0, 1);
        op_st(SWR, 32'h3001, 32'h11223344); cyc(1, 0);
        op_nop(); cyc(0, 0); cyc(0, 0);
        chk("swr_strb", mem_wstrb, 4'b1110);
        chk("swr_data", mem_wdata, 32'h22334400);
        cyc(0, 1); cyc(0, 0);

        // flush keeps buffered stores (including one leaving on the flush edge); reset empties
        op_st(SW, 32'h6000, 32'hA); cyc(1, 0);
        op_st(SW, 32'h6004, 32'hB); cyc(1, 0);
        op_st(SW, 32'h6008, 32'hC); cyc(1, 0);
        op_nop(); cyc(0, 0, 1);
        cyc(0, 0);
        chk("flush_count", sb_count, 3);
        chk("flush_req", mem_req, 1'b1);
        cyc(0, 1); cyc(0, 0);
        chk("flush_drain", sb_count, 2);
        cyc(0, 0, 0, 1); cyc(0, 0);
        chk("rst2_empty", sb_empty, 1'b1);
        chk("rst2_req", mem_req, 1'b0);
        chk("rst2_count", sb_count, 0);

        // two byte stores to the same word
        op_st(SB, 32'h4000, 32'h11); cyc(1, 0);
        op_st(SB, 32'h4001, 32'h22); cyc(1, 0);
        op_nop(); cyc(0, 0); cyc(0, 0);
`ifdef MA_WBUF_MERGE_EN
        chk("merge_count", sb_count, 1);
        chk("merge_strb", mem_wstrb, 4'b0011);
        chk("merge_size", mem_size, 3'd4);
        chk("merge_data", mem_wdata, 32'h00002211);
`else
        chk("nomerge_count", sb_count, 2);
        chk("nomerge_strb", mem_wstrb, 4'b0001);
`endif
        repeat (3) cyc(0, 1);
        cyc(0, 0);

        // random traffic on a few words so conflicts and full buffers occur
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 2))
                0: op_nop();
                1: op_ld(7'(1 << $urandom_range(0, 6)), 32'h7000 + 32'($urandom_range(0, 15)));
                default: op_st(5'(1 << $urandom_range(0, 4)), 32'h7000 + 32'($urandom_range(0, 15)),
                               $urandom);
            endcase
            cyc(($urandom % 4) != 0, ($urandom % 2) != 0, ($urandom % 20) == 0,
                ($urandom % 500) == 0);
        end
        op_nop();
        repeat (20) cyc(0, 1);
        chk("final_empty", sb_empty, 1'b1);
        chk("final_req", mem_req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
